// File: rtl/gl_raster_sequencer_if.sv
// Triangle stream, frame control and rasterizer bus for the raster sequencer.
// master: frame/triangle source plus the rasterizer side; slave: the sequencer.
interface gl_raster_sequencer_if #(
  parameter int unsigned VERTEX_TYPE_SIZE = 96,
  parameter int unsigned COLOR_TYPE_SIZE  = 96,
  parameter int unsigned TRI_CNT_W        = 16
);
  logic                          frame_start;
  logic [TRI_CNT_W-1:0]          frame_tri_count;
  logic                          tri_valid;
  logic                          tri_ready;
  logic [3*VERTEX_TYPE_SIZE-1:0] tri_vertex;
  logic [3*COLOR_TYPE_SIZE-1:0]  tri_color;
  logic [VERTEX_TYPE_SIZE-1:0]   rast_vertex1, rast_vertex2, rast_vertex3;
  logic [COLOR_TYPE_SIZE-1:0]    rast_color1, rast_color2, rast_color3;
  logic                          rast_start;
  logic                          rast_done;
  logic                          busy;
  logic [TRI_CNT_W-1:0]          tris_drawn;
  logic                          frame_done;
  logic                          timeout_err;

  modport master (
    output frame_start, frame_tri_count, tri_valid, tri_vertex, tri_color, rast_done,
    input  tri_ready, rast_vertex1, rast_vertex2, rast_vertex3, rast_color1, rast_color2,
           rast_color3, rast_start, busy, tris_drawn, frame_done, timeout_err
  );

  modport slave (
    input  frame_start, frame_tri_count, tri_valid, tri_vertex, tri_color, rast_done,
    output tri_ready, rast_vertex1, rast_vertex2, rast_vertex3, rast_color1, rast_color2,
           rast_color3, rast_start, busy, tris_drawn, frame_done, timeout_err
  );
endinterface

// File: rtl/gl_raster_sequencer.sv
// Front-end sequencer for the triangle rasterizer: fetches one triangle at a time,
// holds it on registered buses, pulses start, waits for done, counts and watchdogs.
module gl_raster_sequencer #(
  parameter int unsigned VERTEX_TYPE_SIZE = 96,
  parameter int unsigned COLOR_TYPE_SIZE  = 96,
  parameter int unsigned TRI_CNT_W        = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 1048576
) (
  input logic                  clk,
  input logic                  rst,
  gl_raster_sequencer_if.slave bus
);
  localparam int unsigned VW  = VERTEX_TYPE_SIZE;
  localparam int unsigned CW  = COLOR_TYPE_SIZE;
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StStart, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [TRI_CNT_W-1:0] count_q, tris_q, tris_inc;
  logic [WdW-1:0]       wd_q;
  logic                 timeout_q;
  logic [VW-1:0]        v1_q, v2_q, v3_q;
  logic [CW-1:0]        c1_q, c2_q, c3_q;
  logic                 frame_go, accept, done_hit, wd_expired;

  // Qualified events; rast_done and frame_start only matter in their own state.
  always_comb begin
    frame_go   = (state_q == StIdle) && bus.frame_start;
    accept     = (state_q == StFetch) && bus.tri_valid;
    done_hit   = (state_q == StRun) && bus.rast_done;
    wd_expired = (state_q == StRun) && (wd_q == WdLast);
    tris_inc   = tris_q + TRI_CNT_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rast_done wins over the watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.frame_start) begin
          state_d = (bus.frame_tri_count == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (bus.tri_valid) state_d = StStart;
      end
      StStart: state_d = StRun;
      StRun: begin
        if (bus.rast_done) begin
          state_d = (tris_inc == count_q) ? StDone : StFetch;
        end else if (wd_q == WdLast) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state only, so tri_ready never depends on tri_valid.
  always_comb begin
    bus.tri_ready  = (state_q == StFetch);
    bus.rast_start = (state_q == StStart);
    bus.frame_done = (state_q == StDone);
    bus.busy       = (state_q != StIdle);
  end

  // Frame bookkeeping: latched count, progress counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      tris_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (frame_go) begin
        count_q   <= bus.frame_tri_count;
        tris_q    <= '0;
        timeout_q <= 1'b0;
      end
      if (done_hit) begin
        tris_q <= tris_inc;
      end else if (wd_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Watchdog: cleared in START, counts every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (state_q == StStart) begin
      wd_q <= '0;
    end else if (state_q == StRun) begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  // Rasterizer buses load only on accept; the rasterizer reads them combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= '0;
      v2_q <= '0;
      v3_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
    end else if (accept) begin
      v1_q <= bus.tri_vertex[3*VW-1 -: VW];
      v2_q <= bus.tri_vertex[2*VW-1 -: VW];
      v3_q <= bus.tri_vertex[VW-1:0];
      c1_q <= bus.tri_color[3*CW-1 -: CW];
      c2_q <= bus.tri_color[2*CW-1 -: CW];
      c3_q <= bus.tri_color[CW-1:0];
    end
  end

  assign bus.rast_vertex1 = v1_q;
  assign bus.rast_vertex2 = v2_q;
  assign bus.rast_vertex3 = v3_q;
  assign bus.rast_color1  = c1_q;
  assign bus.rast_color2  = c2_q;
  assign bus.rast_color3  = c3_q;
  assign bus.tris_drawn   = tris_q;
  assign bus.timeout_err  = timeout_q;
endmodule

// File: doc/gl_raster_sequencer.md
Name: gl_raster_sequencer

Overview:
Front-end controller for the triangle rasterizer. It accepts a frame command and a stream of triangles (3 vertices + 3 colours), and presents one triangle at a time to the rasterizer. It holds the vertex/colour buses stable, because the rasterizer consumes them combinationally for the whole triangle. It issues a one-cycle start, waits for the rasterizer's done pulse, counts completed triangles, reports frame completion and guards each triangle with a watchdog.

Parameters:
VERTEX_TYPE_SIZE, 96, width of one vertex ({x,y,z} IEEE-754 single, x at MSB)
COLOR_TYPE_SIZE, 96, width of one colour ({r,g,b} IEEE-754 single, r at MSB)
TRI_CNT_W, 16, width of triangle count / progress counter
TIMEOUT_CYCLES, 1048576, max cycles in RUN per triangle before timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
frame_start  in  1  request to begin a frame; sampled only in IDLE
frame_tri_count  in  TRI_CNT_W  number of triangles in frame; latched with frame_start
tri_valid  in  1  upstream triangle available
tri_ready  out  1  sequencer accepts triangle this cycle
tri_vertex  in  3*VERTEX_TYPE_SIZE  {v1,v2,v3}, v1 at MSB
tri_color  in  3*COLOR_TYPE_SIZE  {c1,c2,c3}, c1 at MSB
rast_vertex1/2/3  out  VERTEX_TYPE_SIZE  registered vertices to rasterizer
rast_color1/2/3  out  COLOR_TYPE_SIZE  registered colours to rasterizer
rast_start  out  1  one-cycle start pulse (drives rasterizer fifo_ready)
rast_done  in  1  rasterizer completion pulse (rasterizer raster_ready)
busy  out  1  high in any state other than IDLE
tris_drawn  out  TRI_CNT_W  triangles completed in current frame
frame_done  out  1  one-cycle pulse at frame end
timeout_err  out  1  sticky; set on watchdog expiry, cleared by rst or accepted frame_start

Behaviour:
- Reset values: all outputs 0; rast_vertex*/rast_color* 0; state IDLE; watchdog 0; latched count 0.
- State IDLE: tri_ready=0. On frame_start: latch N=frame_tri_count, clear tris_drawn, clear timeout_err. Then go to DONE if N==0, else to FETCH.
- State FETCH: tri_ready=1 (combinational from state only, not from tri_valid). On tri_valid&tri_ready, register tri_vertex/tri_color slices onto the rast_* buses and go to START. Otherwise stay in FETCH with the buses unchanged.
- State START: rast_start=1 for exactly this cycle; clear watchdog; go to RUN. The buses were updated on the previous edge, so they are stable when the rasterizer samples start.
- State RUN: rast_start=0; watchdog increments each cycle.
  - On rast_done: tris_drawn<=tris_drawn+1; go to DONE if tris_drawn+1==N, else go to FETCH.
  - Else, if watchdog==TIMEOUT_CYCLES-1: set timeout_err and go to DONE; tris_drawn is not incremented.
  - rast_done takes priority over timeout in the same cycle.
- State DONE: frame_done=1 for one cycle; go to IDLE.
- rast_* buses change only on a FETCH accept or on rst; they hold through START, RUN, DONE and IDLE.
- rast_done outside RUN is ignored. The rasterizer has no reset, so a stale pulse after rst must not count.
- frame_start outside IDLE is ignored; no queuing.
- Minimum per-triangle overhead is 2 cycles (FETCH accept, START) plus rasterizer time. Back-to-back triangles are accepted in the cycle after rast_done.
- rst mid-frame: sequencer returns to IDLE next edge. Buses drop to 0, and no frame_done is produced.
- tris_drawn compares at full TRI_CNT_W; no wrap is possible since it stops at N.

Test Plan:
1. rst, then frame_start with count=2 and tri_valid held high; rasterizer model returns rast_done 10 cycles after start. Expect tri_ready for 1 cycle, rast_start 1 cycle after accept, tris_drawn 1 then 2, frame_done a single pulse 1 cycle after the 2nd rast_done, busy low afterwards.
2. frame_start with count=0 -> frame_done pulses 1 cycle after the start (via DONE), no tri_ready, no rast_start, tris_drawn=0.
3. count=3 with tri_valid gapped (low 5 cycles between triangles) -> tri_ready stays high in FETCH, and rast_vertex* buses change only at each accept edge, holding stable during RUN.
4. TIMEOUT_CYCLES=16, no rast_done -> timeout_err set at RUN cycle 16, frame_done pulses, tris_drawn=0. The next frame_start clears timeout_err.
5. Pulse frame_start during RUN, and pulse rast_done while in FETCH -> both ignored; tris_drawn and latched count unchanged.
6. Assert rst during RUN, then pulse rast_done 3 cycles later -> outputs 0, state IDLE, no frame_done, tris_drawn stays 0.
